fcl_layer_sequencer: RTL and testbench

Top-level sequencer for one fully-connected (FCL) layer of the BNN. On a start pulse it walks every output neuron. For each neuron it:
- clears the accumulator,
- issues the weight/input read addresses,
- enables accumulation one cycle after each read to match the 1-cycle synchronous RAM latency,
- writes the neuron result.
It sits between the network-level controller (start/done handshake) and the FCL weight ROM, input buffer, XNOR-popcount accumulator and output buffer.

---
 rtl/fcl_pkg.sv | 22 ++
 rtl/fcl_wrap_counter.sv | 31 +++
 rtl/fcl_layer_sequencer.sv | 133 +++++++++++++
 tb/tb_fcl_layer_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fcl_pkg.sv
// Purpose : shared encodings and per-layer sizing for the FCL layer sequencers.
// Latency : n/a (constants and types only).
// Backpressure: n/a.
package fcl_pkg;

  // Sequencer FSM state encoding (3 bits).
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } fclState_t;

  // Layer geometry of the two FCL instances in the network.
  localparam int FCL1_N_OUT = 112;
  localparam int FCL1_N_IN  = 6;
  localparam int FCL2_N_OUT = 12;
  localparam int FCL2_N_IN  = 1;

endpackage

// File: rtl/fcl_wrap_counter.sv
// Purpose : clear + enable up-counter that wraps from MV back to 0, with terminal-count flag.
// Latency : count updates on the clock edge after en; tc is combinational from the count.
// Backpressure: none; the counter simply holds while en is low.
// Ports   : clk, rstN (async active-low), clr (sync, has priority), en, cnt[WL], tc (cnt==MV).
module fcl_wrap_counter #(
  parameter int WL = 3,
  parameter int MV = 5
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          clr,
  input  logic          en,
  output logic [WL-1:0] cnt,
  output logic          tc
);

  localparam logic [WL-1:0] MAXV = WL'(MV);

  assign tc = (cnt == MAXV);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + WL'(1);
    end
  end

endmodule

// File: rtl/fcl_layer_sequencer.sv
// Purpose : walks every output neuron of one FCL layer: clear acc, read N_IN words, drain, write result.
// Latency : N_IN+3 cycles per neuron; oDONE N_OUT*(N_IN+3)+1 cycles after the accepted iSTART.
// Backpressure: iHOLD stalls reads (and the address counters) in READ only; each held cycle adds one cycle.
// Ports   : iCLK/iRSTn; iSTART (accepted in IDLE), iHOLD; oBUSY, oDONE; oRD_EN, oW_ADDR, oX_ADDR to
//           weight ROM / input buffer; oACC_CLR, oACC_EN to the accumulator; oOUT_WE, oOUT_ADDR to output buffer.
module fcl_layer_sequencer
  import fcl_pkg::*;
#(
  parameter int N_OUT = 112,
  parameter int N_IN  = 6,
  parameter int WA_W  = 10,
  parameter int XA_W  = 3,
  parameter int OA_W  = 7
) (
  input  logic            iCLK,
  input  logic            iRSTn,
  input  logic            iSTART,
  input  logic            iHOLD,
  output logic            oBUSY,
  output logic            oDONE,
  output logic            oRD_EN,
  output logic [WA_W-1:0] oW_ADDR,
  output logic [XA_W-1:0] oX_ADDR,
  output logic            oACC_CLR,
  output logic            oACC_EN,
  output logic            oOUT_WE,
  output logic [OA_W-1:0] oOUT_ADDR
);

  fclState_t       state;
  logic [XA_W-1:0] word;
  logic            wordTc;
  logic [OA_W-1:0] neuron;
  logic            neuronTc;
  logic [WA_W-1:0] wptr;
  logic            rdEn;

  // The only combinational output path: a read is accepted in READ unless the input buffer holds us off.
  assign rdEn      = (state == READ) && !iHOLD;
  assign oRD_EN    = rdEn;

  // Addresses come straight from the counter flops, so they freeze automatically while held.
  assign oX_ADDR   = word;
  assign oW_ADDR   = wptr;
  assign oOUT_ADDR = neuron;

  fcl_wrap_counter #(.WL(XA_W), .MV(N_IN - 1)) uWordCnt (
    .clk  (iCLK),
    .rstN (iRSTn),
    .clr  (state == CLEAR),
    .en   (rdEn),
    .cnt  (word),
    .tc   (wordTc)
  );

  fcl_wrap_counter #(.WL(OA_W), .MV(N_OUT - 1)) uNeuronCnt (
    .clk  (iCLK),
    .rstN (iRSTn),
    .clr  (state == DONE),
    .en   (state == WRITE),
    .cnt  (neuron),
    .tc   (neuronTc)
  );

  // Running weight pointer = neuron*N_IN + word without a multiplier; it only
  // rewinds at the end of the layer, since the words of consecutive neurons are contiguous.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      wptr <= '0;
    end else if (state == DONE) begin
      wptr <= '0;
    end else if (rdEn) begin
      wptr <= wptr + WA_W'(1);
    end
  end

  // FSM with registered outputs: each output is loaded with its value for the state being entered.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state    <= IDLE;
      oBUSY    <= 1'b0;
      oDONE    <= 1'b0;
      oACC_CLR <= 1'b0;
      oACC_EN  <= 1'b0;
      oOUT_WE  <= 1'b0;
    end else begin
      oDONE    <= 1'b0;
      oACC_CLR <= 1'b0;
      oOUT_WE  <= 1'b0;
      // RAM data appears one cycle after the read strobe.
      oACC_EN  <= rdEn;
      case (state)
        IDLE: begin
          if (iSTART) begin
            state    <= CLEAR;
            oBUSY    <= 1'b1;
            oACC_CLR <= 1'b1;
          end
        end
        CLEAR: begin
          state <= READ;
        end
        READ: begin
          if (rdEn && wordTc) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          state   <= WRITE;
          oOUT_WE <= 1'b1;
        end
        WRITE: begin
          if (neuronTc) begin
            state <= DONE;
            oDONE <= 1'b1;
          end else begin
            state    <= CLEAR;
            oACC_CLR <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          oBUSY <= 1'b0;
        end
        default: begin
          state <= IDLE;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fcl_layer_sequencer.sv
module tb_fcl_layer_sequencer;

  logic       clk;
  logic       rstN;

  // Default (FCL1) instance
  logic       start, hold;
  logic       busy, done, rdEn, accEn, accClr, outWe;
  logic [9:0] wAddr;
  logic [2:0] xAddr;
  logic [6:0] outAddr;

  // FCL2 instance (N_OUT=12, N_IN=1)
  logic       start2, hold2;
  logic       busy2, done2, rdEn2, accEn2, accClr2, outWe2;
  logic [3:0] wAddr2;
  logic [0:0] xAddr2;
  logic [3:0] outAddr2;

  int tests = 0;
  int fails = 0;

  fcl_layer_sequencer dut (
    .iCLK(clk), .iRSTn(rstN), .iSTART(start), .iHOLD(hold),
    .oBUSY(busy), .oDONE(done), .oRD_EN(rdEn), .oW_ADDR(wAddr), .oX_ADDR(xAddr),
    .oACC_CLR(accClr), .oACC_EN(accEn), .oOUT_WE(outWe), .oOUT_ADDR(outAddr)
  );

  fcl_layer_sequencer #(.N_OUT(12), .N_IN(1), .WA_W(4), .XA_W(1), .OA_W(4)) dut2 (
    .iCLK(clk), .iRSTn(rstN), .iSTART(start2), .iHOLD(hold2),
    .oBUSY(busy2), .oDONE(done2), .oRD_EN(rdEn2), .oW_ADDR(wAddr2), .oX_ADDR(xAddr2),
    .oACC_CLR(accClr2), .oACC_EN(accEn2), .oOUT_WE(outWe2), .oOUT_ADDR(outAddr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [29:0] packOut(input logic b, d, r, a, c, w,
                                          input logic [9:0] wa, input logic [2:0] xa,
                                          input logic [6:0] oa);
    return {b, d, r, a, c, w, wa, xa, oa};
  endfunction

  // One full FCL1 layer started at relative cycle 0, with optional extra starts and holds.
  task automatic runLayer(input string tag, input int holdFrom, input int holdLen,
                          input bit rndHold, input int s1, input int s2,
                          input int expDone, input int tail);
    int doneCyc = -1;
    int expW = 0, expOut = 0, accCnt = 0, busyCnt = 0;
    int wErr = 0, outErr = 0, accErr = 0, accEnErr = 0, holdErr = 0, busyAfter = 0;
    logic prevRd = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      start = (k == 0) || (k == s1) || (k == s2);
      hold  = rndHold ? ($urandom_range(0, 3) == 0) : (k >= holdFrom && k < holdFrom + holdLen);
      @(negedge clk);
      if (busy) busyCnt++;
      if (accEn !== prevRd) accEnErr++;
      prevRd = rdEn;
      if (accClr) accCnt = 0;
      if (accEn) accCnt++;
      if (!rndHold && holdLen > 0) begin
        if (k >= holdFrom && k < holdFrom + holdLen &&
            (rdEn !== 1'b0 || wAddr != 10'd32 || xAddr != 3'd2)) holdErr++;
        if (k > holdFrom && k <= holdFrom + holdLen && accEn !== 1'b0) holdErr++;
      end
      if (rdEn) begin
        if (int'(wAddr) != expW || int'(xAddr) != expW % 6) wErr++;
        expW++;
      end
      if (outWe) begin
        if (int'(outAddr) != expOut) outErr++;
        if (accCnt != 6) accErr++;
        expOut++;
      end
      if (done) begin
        doneCyc = k;
        break;
      end
    end
    if (expDone >= 0) check({tag, " done cycle"}, doneCyc, expDone);
    else              check({tag, " done seen"}, longint'(doneCyc >= 1009), 1);
    check({tag, " write count"}, expOut, 112);
    check({tag, " read count"}, expW, 672);
    check({tag, " w/x addr errors"}, wErr, 0);
    check({tag, " out addr errors"}, outErr, 0);
    check({tag, " acc per neuron errors"}, accErr, 0);
    check({tag, " acc_en delay errors"}, accEnErr, 0);
    check({tag, " hold freeze errors"}, holdErr, 0);
    check({tag, " busy cycles"}, busyCnt, doneCyc);
    if (tail > 0) begin
      for (int k = 0; k < tail; k++) begin
        @(posedge clk); #1;
        start = 1'b0;
        hold  = 1'b0;
        @(negedge clk);
        if (busy || done) busyAfter++;
      end
      check({tag, " idle after done"}, busyAfter, 0);
    end
  endtask

  typedef struct {
    logic start, hold;
    logic busy, done, rd, acc, clr, we;
    int   w, x, o;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int nDone, nWe, nBusy, err2, done2Cyc, ph, n;
    rstN = 1'b0; start = 0; hold = 0; start2 = 0; hold2 = 0;

    //              st ho  bu dn rd ac cl we   w  x  o
    vecs[0]  = '{1, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0};
    vecs[1]  = '{0, 0,  1, 0, 0, 0, 1, 0,  0, 0, 0};
    vecs[2]  = '{0, 0,  1, 0, 1, 0, 0, 0,  0, 0, 0};
    vecs[3]  = '{0, 1,  1, 0, 0, 1, 0, 0,  1, 1, 0};
    vecs[4]  = '{1, 0,  1, 0, 1, 0, 0, 0,  1, 1, 0};
    vecs[5]  = '{0, 0,  1, 0, 1, 1, 0, 0,  2, 2, 0};
    vecs[6]  = '{0, 0,  1, 0, 1, 1, 0, 0,  3, 3, 0};
    vecs[7]  = '{0, 0,  1, 0, 1, 1, 0, 0,  4, 4, 0};
    vecs[8]  = '{0, 0,  1, 0, 1, 1, 0, 0,  5, 5, 0};
    vecs[9]  = '{0, 1,  1, 0, 0, 1, 0, 0,  6, 0, 0};
    vecs[10] = '{0, 1,  1, 0, 0, 0, 0, 1,  6, 0, 0};
    vecs[11] = '{0, 0,  1, 0, 0, 0, 1, 0,  6, 0, 1};
    vecs[12] = '{0, 0,  1, 0, 1, 0, 0, 0,  6, 0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", packOut(busy, done, rdEn, accEn, accClr, outWe, wAddr, xAddr, outAddr), 0);
    check("reset outputs fcl2", {busy2, done2, rdEn2, accEn2, accClr2, outWe2, wAddr2, xAddr2, outAddr2}, 0);
    @(posedge clk); #1 rstN = 1'b1;

    // FCL2: CLEAR, READ, DRAIN, WRITE per neuron, done at cycle 49
    err2 = 0; done2Cyc = -1;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      start2 = (k == 0);
      @(negedge clk);
      if (k >= 1 && k <= 48) begin
        ph = (k - 1) % 4;
        n  = (k - 1) / 4;
        if (busy2 !== 1'b1 || accClr2 !== (ph == 0) || rdEn2 !== (ph == 1) ||
            accEn2 !== (ph == 2) || outWe2 !== (ph == 3) || xAddr2 !== 1'b0) err2++;
        if (ph == 1 && int'(wAddr2) != n) err2++;
        if (ph == 3 && int'(outAddr2) != n) err2++;
      end
      if (done2) begin
        done2Cyc = k;
        break;
      end
    end
    check("fcl2 sequence errors", err2, 0);
    check("fcl2 done cycle", done2Cyc, 49);

    // Table-driven opening of an FCL1 layer (hold in READ, hold in DRAIN/WRITE, start while busy)
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #1;
      start = vecs[k].start;
      hold  = vecs[k].hold;
      @(negedge clk);
      check($sformatf("vector %0d", k),
            packOut(busy, done, rdEn, accEn, accClr, outWe, wAddr, xAddr, outAddr),
            packOut(vecs[k].busy, vecs[k].done, vecs[k].rd, vecs[k].acc, vecs[k].clr,
                    vecs[k].we, 10'(vecs[k].w), 3'(vecs[k].x), 7'(vecs[k].o)));
    end
    for (int k = 13; k < 300; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      hold  = 1'b0;
    end
    @(negedge clk);
    check("busy before reset", busy, 1);

    // Reset mid-layer at cycle 300 for 2 cycles
    @(posedge clk); #1 rstN = 1'b0;
    #1;
    check("mid-layer reset outputs", packOut(busy, done, rdEn, accEn, accClr, outWe, wAddr, xAddr, outAddr), 0);
    @(posedge clk);
    @(posedge clk); #1 rstN = 1'b1;
    nDone = 0; nWe = 0; nBusy = 0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (done) nDone++;
      if (outWe) nWe++;
      if (busy) nBusy++;
    end
    check("no done after reset", nDone, 0);
    check("no write after reset", nWe, 0);
    check("no busy after reset", nBusy, 0);

    // Clean run with starts at 0, 50 and 1009 (only the first accepted)
    runLayer("clean", 0, 0, 1'b0, 50, 1009, 1009, 4);
    // Hold 3 cycles while oX_ADDR=2 on neuron 5
    runLayer("hold", 49, 3, 1'b0, -1, -1, 1012, 0);
    // Back-to-back start the cycle after DONE, with random holds
    runLayer("random", 0, 0, 1'b1, -1, -1, -1, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
